serial_adder_ctrl: RTL and testbench
====================================

// Module: serial_adder_ctrl
// PURPOSE
//  Bit-serial add sequencer for the external 1-bit full adder (a,b,c -> Sum,Carry).
//  Latches two WIDTH-bit operands and a carry-in, then drives the full adder one bit
//  per clock, LSB first. The carry is registered between bits.
//  Collects the sum bits and presents result/cout on a valid/ready output handshake.
//  Sits between an operand producer and the shared full-adder datapath.
// PARAMETERS
//  WIDTH  8  operand/result width in bits; legal range 2..32
//  CNT_W  5  bit-counter width; must satisfy 2**CNT_W > WIDTH
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      operand request
//  in_ready   out  1      block can accept operands (IDLE only)
//  op_a       in   WIDTH  operand A
//  op_b       in   WIDTH  operand B
//  cin        in   1      initial carry-in
//  fa_a       out  1      to full adder a
//  fa_b       out  1      to full adder b
//  fa_c       out  1      to full adder c (registered carry)
//  fa_sum     in   1      from full adder Sum
//  fa_carry   in   1      from full adder Carry
//  out_valid  out  1      result available
//  out_ready  in   1      consumer takes result
//  result     out  WIDTH  sum bits
//  cout       out  1      final carry-out
//  busy       out  1      high in RUN or DONE
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE; in_ready=1; out_valid=0; busy=0; result=0;
//    cout=0; fa_a/fa_b/fa_c=0; counter=0; carry reg=0. All outputs are registered or
//    decoded from registered state only.
//  - FSM states: IDLE, RUN, DONE.
//  - IDLE: in_ready=1. When in_valid=1 at a rising edge: load a_sh=op_a, b_sh=op_b,
//    carry=cin, cnt=0, result=0, then go to RUN. in_valid=0 keeps the FSM in IDLE.
//  - RUN: in_ready=0; fa_a=a_sh[0]; fa_b=b_sh[0]; fa_c=carry. fa_* are 0 outside RUN.
//    Each edge: result <= {fa_sum, result[WIDTH-1:1]}; carry <= fa_carry;
//    a_sh, b_sh shift right one bit; cnt <= cnt+1.
//    When cnt==WIDTH-1 at an edge: cout <= fa_carry and the FSM goes to DONE.
//  - Latency: operands accepted at edge E0; out_valid is high after edge E(WIDTH),
//    i.e. exactly WIDTH clocks later.
//  - DONE: out_valid=1; result and cout are held stable until the handshake completes.
//    out_ready=1 at an edge -> go to IDLE; out_valid falls and in_ready rises next cycle.
//    No back-to-back overlap: in_valid is ignored outside IDLE.
//  - Arithmetic: {cout,result} = op_a + op_b + cin, modulo 2**(WIDTH+1); no saturation.
//  - in_valid/op_* may change during RUN/DONE with no effect; the latched copies are used.
//  - rst_n asserted mid-RUN or mid-DONE: immediate return to reset values. A partial
//    result is never presented.
//  - busy = (state != IDLE).
// CONFIGURATION
//  SERIAL_SUB_EN defined: adds input port 'sub' (1 bit), sampled with the operands.
//    - When sub=1 at acceptance: b_sh loads ~op_b and carry loads 1; cin is ignored.
//      Result = op_a - op_b (two's complement); cout=1 means no borrow.
//    - When sub=0: identical to the base add.
//  SERIAL_SUB_EN undefined: no 'sub' port, add only.
// TESTING
//  All benches instantiate the full adder as the datapath.
//  1. Reset: rst_n=0 -> in_ready=1, out_valid=0, busy=0, result=0, cout=0.
//  2. Add, WIDTH=8, A=8'h3C, B=8'h5A, cin=0 -> out_valid exactly 8 clocks after accept,
//     result=8'h96, cout=0.
//  3. Wrap-around: A=8'hFF, B=8'h01, cin=1 -> result=8'h01, cout=1. Also
//     A=8'hFF, B=8'hFF, cin=1 -> result=8'hFF, cout=1.
//  4. Backpressure: hold out_ready=0 for 5 cycles in DONE; toggle in_valid/op_a meanwhile
//     -> result/cout stable, in_ready=0. out_ready=1 -> IDLE next cycle.
//  5. Reset mid-RUN: pull rst_n low after 3 bit-cycles -> reset values, no out_valid.
//     New request after release -> correct sum.
//  6. SERIAL_SUB_EN: sub=1, A=8'h10, B=8'h01 -> result=8'h0F, cout=1;
//     A=8'h01, B=8'h02 -> result=8'hFF, cout=0.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add sequencer: drives an external 1-bit full adder LSB first, result after WIDTH clocks.
// Optional SERIAL_SUB_EN adds a 'sub' input that turns the operation into op_a - op_b.
module serial_adder_ctrl #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             cin,
`ifdef SERIAL_SUB_EN
   input  logic             sub,
`endif
   output logic             fa_a,
   output logic             fa_b,
   output logic             fa_c,
   input  logic             fa_sum,
   input  logic             fa_carry,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             busy
);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         result_q <= '0;
         cnt_q    <= '0;
         carry_q  <= 1'b0;
         cout_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         result_q <= result_d;
         cnt_q    <= cnt_d;
         carry_q  <= carry_d;
         cout_q   <= cout_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      result_d = result_q;
      cnt_d    = cnt_q;
      carry_d  = carry_q;
      cout_d   = cout_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_sh_d   = op_a;
               b_sh_d   = op_b;
               carry_d  = cin;
`ifdef SERIAL_SUB_EN
               // Subtract as a + ~b + 1; the supplied carry-in is not used.
               if (sub) begin
                  b_sh_d  = ~op_b;
                  carry_d = 1'b1;
               end
`endif
               cnt_d    = '0;
               result_d = '0;
               state_d  = RUN;
            end
         end
         RUN: begin
            result_d = {fa_sum, result_q[WIDTH-1:1]};
            carry_d  = fa_carry;
            a_sh_d   = a_sh_q >> 1;
            b_sh_d   = b_sh_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_BIT) begin
               cout_d  = fa_carry;
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Full-adder drive is gated so the shared datapath sees zeros when idle.
   assign fa_a      = (state_q == RUN) & a_sh_q[0];
   assign fa_b      = (state_q == RUN) & b_sh_q[0];
   assign fa_c      = (state_q == RUN) & carry_q;
   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign result    = result_q;
   assign cout      = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl with a behavioural full adder and an arithmetic reference model.
module tb_serial_adder_ctrl;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] op_a = '0;
   logic [W-1:0] op_b = '0;
   logic         cin = 1'b0;
`ifdef SERIAL_SUB_EN
   logic         sub = 1'b0;
`endif
   logic         fa_a, fa_b, fa_c, fa_sum, fa_carry;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] result;
   logic         cout;
   logic         busy;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   assign fa_sum   = fa_a ^ fa_b ^ fa_c;
   assign fa_carry = (fa_a & fa_b) | (fa_a & fa_c) | (fa_b & fa_c);

   serial_adder_ctrl #(.WIDTH(W), .CNT_W(5)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .op_a(op_a), .op_b(op_b), .cin(cin),
`ifdef SERIAL_SUB_EN
      .sub(sub),
`endif
      .fa_a(fa_a), .fa_b(fa_b), .fa_c(fa_c), .fa_sum(fa_sum), .fa_carry(fa_carry),
      .out_valid(out_valid), .out_ready(out_ready), .result(result), .cout(cout), .busy(busy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: a transaction is live from acceptance; after W clocks the sum is offered.
   bit          m_active = 1'b0;
   int          m_cnt = 0;
   logic [31:0] m_a, m_b, m_c0;
   logic [W:0]  m_exp;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_active = 1'b0;
         m_cnt    = 0;
      end else if (!m_active) begin
         if (in_valid) begin
            m_active = 1'b1;
            m_cnt    = 0;
            m_a      = 32'(op_a);
            m_b      = 32'(op_b);
            m_c0     = 32'(cin);
`ifdef SERIAL_SUB_EN
            if (sub) begin
               m_b  = 32'(W'(~op_b));
               m_c0 = 32'd1;
            end
`endif
            m_exp = (W+1)'(m_a + m_b + m_c0);
         end
      end else if (m_cnt < W) begin
         m_cnt++;
      end else if (out_ready) begin
         m_active = 1'b0;
      end
   end

   bit checking = 1'b0;

   always @(negedge clk) begin
      if (checking) begin
         automatic bit run  = m_active && (m_cnt < W);
         automatic bit done = m_active && (m_cnt == W);
         chk("in_ready", 32'(in_ready), 32'(!m_active));
         chk("busy", 32'(busy), 32'(m_active));
         chk("out_valid", 32'(out_valid), 32'(done));
         if (run) begin
            automatic logic [31:0] mask = (32'd1 << m_cnt) - 32'd1;
            automatic logic [31:0] cin_k = ((m_a & mask) + (m_b & mask) + m_c0) >> m_cnt;
            chk("fa_a", 32'(fa_a), 32'(m_a[m_cnt]));
            chk("fa_b", 32'(fa_b), 32'(m_b[m_cnt]));
            chk("fa_c", 32'(fa_c), 32'(cin_k[0]));
         end else begin
            chk("fa_idle", {29'd0, fa_a, fa_b, fa_c}, 32'd0);
         end
         if (done) begin
            chk("result", 32'(result), 32'(m_exp[W-1:0]));
            chk("cout", 32'(cout), 32'(m_exp[W]));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_result"}, 32'(result), 32'd0);
      chk({tag, "_cout"}, 32'(cout), 32'd0);
      chk({tag, "_fa"}, {29'd0, fa_a, fa_b, fa_c}, 32'd0);
   endtask

   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                         input logic s, input logic [W-1:0] exp_res, input logic exp_cout,
                         input int hold);
      int n;
      logic [W-1:0] held;
      op_a = a; op_b = b; cin = c; in_valid = 1'b1;
`ifdef SERIAL_SUB_EN
      sub = s;
`else
      if (s) $display("note: subtract vector skipped in add-only build");
`endif
      step();
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 50) begin
         step();
         n++;
      end
      chk("latency", 32'(n), 32'(W));
      chk("lit_result", 32'(result), 32'(exp_res));
      chk("lit_cout", 32'(cout), 32'(exp_cout));
      held = result;
      for (int i = 0; i < hold; i++) begin
         in_valid = ~in_valid;
         op_a     = op_a ^ 8'hA5;
         step();
         chk("hold_result", 32'(result), 32'(held));
         chk("hold_in_ready", 32'(in_ready), 32'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("after_hs_in_ready", 32'(in_ready), 32'd1);
      chk("after_hs_out_valid", 32'(out_valid), 32'd0);
   endtask

   initial begin
      #12;
      check_reset_values("reset");
      rst_n = 1'b1;
      step();
      checking = 1'b1;

      run_op(8'h3C, 8'h5A, 1'b0, 1'b0, 8'h96, 1'b0, 0);
      run_op(8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 0);
      run_op(8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 0);
      run_op(8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1);
      run_op(8'h81, 8'h7E, 1'b0, 1'b0, 8'hFF, 1'b0, 5);

      // Abort mid-transaction: no result may ever be presented.
      op_a = 8'h12; op_b = 8'h34; cin = 1'b0; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      repeat (3) step();
      rst_n = 1'b0;
      #1;
      check_reset_values("midrun_reset");
      step();
      rst_n = 1'b1;
      step();
      run_op(8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 1'b0, 0);

`ifdef SERIAL_SUB_EN
      run_op(8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1, 0);
      run_op(8'h01, 8'h02, 1'b1, 1'b1, 8'hFF, 1'b0, 2);
      run_op(8'h3C, 8'h5A, 1'b0, 1'b0, 8'h96, 1'b0, 0);
`endif

      repeat (2) step();
      checking = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, expected finish before 200000");
      $fatal(1);
   end

endmodule
